// File: rtl/fifo_rd_packer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_rd_packer_if - valid/ready bus carrying packed words + count   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface fifo_rd_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
);
  localparam int CW = $clog2(PACK + 1);

  logic [DATA_WIDTH*PACK-1:0] m_data;
  logic [CW-1:0]              m_count;
  logic                       m_valid;
  logic                       m_ready;

  modport master (
    output m_data,
    output m_count,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_count,
    input  m_valid,
    output m_ready
  );
endinterface : fifo_rd_packer_if
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_rd_packer - pops FIFO beats and packs PACK of them per word    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  wire                   rdclk,
  input  wire                   rrst,
  input  wire                   fifo_empty,
  input  wire  [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  rd_en,
  input  wire                   flush,
  fifo_rd_packer_if.master      m_if
);

  localparam int CW = $clog2(PACK + 1);

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;

  logic [CW-1:0]              r_cnt;
  logic                       r_inflight;
  logic [DATA_WIDTH*PACK-1:0] r_acc;
  logic [DATA_WIDTH*PACK-1:0] r_m_data;
  logic [CW-1:0]              r_m_count;
  logic                       r_m_valid;

  logic                       w_xfer;
  logic                       w_out_free;
  logic                       w_move_full;
  logic                       w_move_part;
  logic                       w_move;
  logic                       w_flush_set;
  logic [CW-1:0]              w_eff_cnt;
  logic [CW:0]                w_level;
  logic [CW:0]                w_issue_level;
  logic                       w_rd_en;

  assign w_xfer     = r_m_valid & m_if.m_ready;
  assign w_out_free = ~r_m_valid | m_if.m_ready;

  // DRAIN is the sticky flush-pending condition: pops stop until the partial word leaves
  always_comb begin
    w_state_nxt   = r_state;
    w_flush_set   = 1'b0;
    w_move_part   = 1'b0;
    w_move_full   = 1'b0;
    w_move        = 1'b0;
    w_eff_cnt     = r_cnt;
    w_rd_en       = 1'b0;
    w_level       = {1'b0, r_cnt} + {{CW{1'b0}}, r_inflight};
    w_issue_level = '0;

    w_move_full = (r_cnt == CW'(PACK)) && w_out_free;

    case (r_state)
      S_FILL: begin
        w_flush_set = flush && (w_level != '0) && (w_level < (CW+1)'(PACK));
        if (w_flush_set) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_move_part = ~r_inflight && w_out_free;
        if (w_move_part) begin
          w_state_nxt = S_FILL;
        end
      end
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase

    w_move = w_move_full | w_move_part;
    if (w_move) begin
      w_eff_cnt = '0;
    end

    // Counting the beat still in flight keeps total pops per word at PACK
    w_issue_level = {1'b0, w_eff_cnt} + {{CW{1'b0}}, r_inflight};
    w_rd_en = ~rrst && ~fifo_empty && (r_state == S_FILL) &&
              (w_issue_level < (CW+1)'(PACK));
  end

  always_ff @(posedge rdclk) begin
    if (rrst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge rdclk) begin
    if (rrst) begin
      r_cnt      <= '0;
      r_inflight <= 1'b0;
      r_acc      <= '0;
      r_m_data   <= '0;
      r_m_count  <= '0;
      r_m_valid  <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_move) begin
        // Clearing acc here is what leaves unused lanes of a partial word at zero
        r_m_data  <= r_acc;
        r_m_count <= r_cnt;
        r_m_valid <= 1'b1;
        r_acc     <= '0;
        r_cnt     <= '0;
      end else begin
        if (w_xfer) begin
          r_m_valid <= 1'b0;
        end
        if (r_inflight) begin
          for (int i = 0; i < PACK; i++) begin
            if (r_cnt == CW'(i)) begin
              r_acc[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data_out;
            end
          end
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign rd_en          = w_rd_en;
  assign m_if.m_data    = r_m_data;
  assign m_if.m_count   = r_m_count;
  assign m_if.m_valid   = r_m_valid;

endmodule : fifo_rd_packer
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fifo_rd_packer - directed vectors against a behavioural FIFO     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_fifo_rd_packer;
  localparam int DW = 8;
  localparam int PK = 4;

  logic          rdclk = 1'b0;
  logic          rrst  = 1'b1;
  logic          flush = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data_out;
  logic          rd_en;

  fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK(PK)) mif ();

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .rdclk         (rdclk),
    .rrst          (rrst),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .rd_en         (rd_en),
    .flush         (flush),
    .m_if          (mif)
  );

  always #5 rdclk = ~rdclk;

  // Behavioural FIFO read port: data appears the cycle after an accepted pop
  logic [7:0] fmem [0:63];
  int wp   = 0;
  int rp   = 0;
  int pops = 0;
  int cyc  = 0;
  assign fifo_empty = (wp == rp);

  always @(posedge rdclk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      fifo_data_out <= fmem[rp[5:0]];
      rp            <= rp + 1;
      pops          <= pops + 1;
    end
  end

  logic [31:0] wdata  [0:31];
  logic [2:0]  wcnt   [0:31];
  int          wstamp [0:31];
  int          nwords = 0;
  int          vcyc   = 0;

  always @(negedge rdclk) begin
    if (mif.m_valid) vcyc <= vcyc + 1;
    if (mif.m_valid && mif.m_ready && nwords < 32) begin
      wdata[nwords]  <= mif.m_data;
      wcnt[nwords]   <= mif.m_count;
      wstamp[nwords] <= cyc;
      nwords         <= nwords + 1;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rdclk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    fmem[wp[5:0]] = b;
    wp = wp + 1;
  endtask

  task automatic do_reset();
    rrst  = 1'b1;
    flush = 1'b0;
    tick(2);
    rrst  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (rp != wp && k < budget) begin
      tick(1);
      k++;
    end
    chk("fifo_drain", rp == wp, 1);
  endtask

  task automatic wait_words(input int target, input int budget);
    int k;
    k = 0;
    while (nwords < target && k < budget) begin
      tick(1);
      k++;
    end
    chk("word_arrival", nwords >= target, 1);
  endtask

  typedef struct {
    int          nb;
    logic [31:0] beats;
    bit          fl;
    logic [31:0] ed;
    logic [2:0]  ec;
  } vec_t;

  vec_t vt [0:4];

  initial begin
    int          p0, w0, v0, bad_rd, bad_v;
    logic [31:0] tmp;

    vt[0] = '{nb: 4, beats: 32'h44332211, fl: 1'b0, ed: 32'h44332211, ec: 3'd4};
    vt[1] = '{nb: 3, beats: 32'h00CCBBAA, fl: 1'b1, ed: 32'h00CCBBAA, ec: 3'd3};
    vt[2] = '{nb: 1, beats: 32'h00000005, fl: 1'b1, ed: 32'h00000005, ec: 3'd1};
    vt[3] = '{nb: 4, beats: 32'hEFBEADDE, fl: 1'b0, ed: 32'hEFBEADDE, ec: 3'd4};
    vt[4] = '{nb: 2, beats: 32'h00003412, fl: 1'b1, ed: 32'h00003412, ec: 3'd2};

    mif.m_ready = 1'b1;
    tick(2);
    chk("reset_valid", mif.m_valid, 0);
    chk("reset_data",  mif.m_data,  0);
    chk("reset_count", mif.m_count, 0);
    chk("reset_rd_en", rd_en,       0);
    rrst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_reset();
      mif.m_ready = 1'b1;
      p0 = pops; w0 = nwords; v0 = vcyc;
      tmp = vt[i].beats;
      for (int k = 0; k < vt[i].nb; k++) push(tmp[8*k +: 8]);
      wait_drain(30);
      tick(3);
      if (vt[i].fl) begin
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
      end
      wait_words(w0 + 1, 30);
      tick(4);
      chk("vec_data",   wdata[w0],   vt[i].ed);
      chk("vec_count",  wcnt[w0],    vt[i].ec);
      chk("vec_nwords", nwords - w0, 1);
      chk("vec_pops",   pops - p0,   vt[i].nb);
      chk("vec_vcyc",   vcyc - v0,   1);
    end

    // Back-pressure: two words held, then released on consecutive accepts
    do_reset();
    mif.m_ready = 1'b0;
    p0 = pops; w0 = nwords;
    for (int k = 1; k <= 8; k++) push(8'(k));
    tick(30);
    chk("bp_pops",   pops - p0,    8);
    chk("bp_valid",  mif.m_valid,  1);
    chk("bp_data",   mif.m_data,   32'h04030201);
    chk("bp_count",  mif.m_count,  4);
    chk("bp_rd_en",  rd_en,        0);
    chk("bp_nwords", nwords - w0,  0);
    mif.m_ready = 1'b1;
    wait_words(w0 + 2, 20);
    chk("bp_word0",  wdata[w0],     32'h04030201);
    chk("bp_word1",  wdata[w0 + 1], 32'h08070605);
    chk("bp_consec", wstamp[w0 + 1] - wstamp[w0], 1);
    tick(3);
    chk("bp_idle",   mif.m_valid,  0);

    // Flush raised in the cycle of the second pop
    rrst = 1'b1;
    flush = 1'b0;
    mif.m_ready = 1'b1;
    tick(2);
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    p0 = pops; w0 = nwords;
    rrst = 1'b0;
    #1;
    chk("fl2_rd1", rd_en, 1);
    tick(1);
    chk("fl2_rd2", rd_en, 1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("fl2_rd_drop", rd_en, 0);
    wait_words(w0 + 1, 20);
    tick(1);
    chk("fl2_data",  wdata[w0], 32'h0000BBAA);
    chk("fl2_count", wcnt[w0],  2);
    wait_drain(20);
    tick(3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_words(w0 + 2, 20);
    chk("fl2_next_data",  wdata[w0 + 1], 32'h0000DDCC);
    chk("fl2_next_count", wcnt[w0 + 1],  2);
    chk("fl2_pops",       pops - p0,     4);

    // Reset after two captures discards the partial word
    do_reset();
    mif.m_ready = 1'b1;
    push(8'h10); push(8'h20);
    wait_drain(20);
    tick(2);
    push(8'h5A); push(8'h6B); push(8'h7C); push(8'h8D);
    rrst = 1'b1;
    #1;
    chk("rst_rd_en", rd_en, 0);
    tick(1);
    chk("rst_valid", mif.m_valid, 0);
    chk("rst_data",  mif.m_data,  0);
    rrst = 1'b0;
    p0 = pops; w0 = nwords;
    wait_words(w0 + 1, 30);
    tick(3);
    chk("rst_word",  wdata[w0], 32'h8D7C6B5A);
    chk("rst_count", wcnt[w0],  4);
    chk("rst_pops",  pops - p0, 4);

    // Empty FIFO with flush pulses: nothing may happen
    do_reset();
    mif.m_ready = 1'b1;
    bad_rd = 0; bad_v = 0;
    for (int c = 0; c < 50; c++) begin
      flush = (c % 7 == 3);
      @(negedge rdclk);
      if (rd_en) bad_rd++;
      if (mif.m_valid) bad_v++;
      @(posedge rdclk);
      #1;
    end
    flush = 1'b0;
    chk("empty_rd_en", bad_rd, 0);
    chk("empty_valid", bad_v,  0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_fifo_rd_packer
`default_nettype wire

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side drain stage sitting directly downstream of asynchronous_fifo, entirely in the rdclk domain.
- Pops DATA_WIDTH beats from the FIFO read port (rd_en / data_out / fifo_empty) and packs PACK beats into one wide word.
- Presents each word on a valid/ready master interface.
- A flush request emits a partially filled word with its beat count.

Parameters:
- DATA_WIDTH, 8, width of one FIFO beat; must equal the FIFO data width.
- PACK, 4, beats per output word; legal range 2..16.
- CW, $clog2(PACK+1), width of the beat-count fields; derived, not overridden.

Ports:
- rdclk  in  1  read-domain clock, the same clock as the FIFO read side.
- rrst  in  1  synchronous, active-high reset, sampled on rdclk rising edge.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data_out  in  DATA_WIDTH  FIFO data_out; valid the cycle after an accepted rd_en.
- rd_en  out  1  FIFO pop request; combinational.
- flush  in  1  single-cycle request to emit the partial word.
- m_data  out  DATA_WIDTH*PACK  packed word; first-popped beat in lane 0 (LSBs).
- m_count  out  CW  number of valid lanes in m_data (1..PACK).
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.

Behaviour:
- Reset (rrst=1 at an edge): cnt=0, inflight=0, flush_pend=0, m_valid=0, m_data=0, m_count=0.
  - rd_en is forced to 0 while rrst=1.
  - A beat in flight at reset is discarded.
  - FIFO contents are not touched.
- Read latency:
  - A pop is "issued" in a cycle with rd_en=1 (rd_en is only driven when fifo_empty=0).
  - The inflight register is set for the next cycle.
  - In that next cycle fifo_data_out is captured into lane cnt of acc, and cnt increments.
- Handshake and transfer:
  - xfer_out = m_valid & m_ready.
  - out_free = !m_valid | m_ready.
- Full-word move:
  - Condition: cnt==PACK & out_free.
  - acc → m_data, m_count=PACK, m_valid=1, cnt→0.
  - acc lanes are cleared to 0 on every move.
- Flush:
  - flush=1 with cnt+inflight>0 and cnt+inflight<PACK sets flush_pend (sticky).
  - flush is ignored when cnt+inflight==0 or cnt+inflight==PACK; the full word goes out normally.
  - While flush_pend=1, rd_en=0.
  - Once inflight=0 and out_free: acc → m_data (unused lanes 0), m_count=cnt, m_valid=1, cnt→0, flush_pend→0.
- m_valid clears on xfer_out when no new word loads in the same cycle.
  - m_data and m_count hold stable while m_valid & !m_ready.
- rd_en generation:
  - eff_cnt = (move this cycle) ? 0 : cnt.
  - rd_en = !rrst & !fifo_empty & !flush_pend & (eff_cnt + inflight < PACK).
  - The accumulator can never overflow; at most PACK beats are popped per word.
- Back-pressure:
  - With m_valid=1 and m_ready=0, acc fills to PACK and pops stop.
  - At most 2*PACK beats are held inside the block.
- Throughput:
  - Sustained rate is PACK beats per PACK+1 rdclk cycles with fifo_empty=0 and m_ready=1.
  - One bubble per word, in the cycle where the last beat is captured.
- Simultaneous events:
  - A capture and a move never coincide for the same lane (cnt==PACK blocks issue).
  - xfer_out and a new load in the same cycle keep m_valid=1 with the new data.
- Implementation: two-state control FSM.
  - FILL → DRAIN when flush_pend is set.
  - DRAIN → FILL after the partial word loads.
  - The datapath implements the move logic above.

Test Plan (DATA_WIDTH=8, PACK=4):
- FIFO holds 0x11,0x22,0x33,0x44, m_ready=1 → exactly four rd_en pulses; one word m_data=0x44332211, m_count=4, m_valid for 1 cycle.
- FIFO holds 0x01..0x08, m_ready=0 → m_valid holds 0x04030201; rd_en pulses total 8, then stops. Raise m_ready → 0x04030201 then 0x08070605 on consecutive accepts.
- FIFO holds 0xAA,0xBB,0xCC, then empty; pulse flush → m_data=0x00CCBBAA, m_count=3; cnt returns to 0.
- Flush pulsed in the cycle of the 2nd rd_en → rd_en drops; m_data=0x0000BBAA, m_count=2. The 3rd FIFO beat lands in lane 0 of the next word.
- rrst for 1 cycle after two captures → m_valid=0, rd_en=0 that cycle. The next four beats 0x5A,0x6B,0x7C,0x8D give m_data=0x8D7C6B5A.
- fifo_empty held 1 for 50 cycles with flush pulses → rd_en never asserts; m_valid stays 0.
